// File: rtl/baser_tx_gearbox_64.sv
`default_nettype none
// ============================================================================
//  Module   : baser_tx_gearbox_64
//  Purpose  : 66b -> 64b BASE-R transmit gearbox. 32 blocks per 33 cycles;
//             the pause cycle drains the accumulated residue.
//  Revision : 1.0  initial release
// ============================================================================
module baser_tx_gearbox_64 #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    output logic                  tx_pause,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [5:0]            tx_seq
);

    localparam int         BLK_W    = DATA_WIDTH + HDR_WIDTH;
    localparam logic [5:0] SEQ_LAST = 6'd32;

    generate
        if (DATA_WIDTH != 64 || HDR_WIDTH != 2) begin : g_bad_params
            $error("baser_tx_gearbox_64 supports only DATA_WIDTH=64, HDR_WIDTH=2");
        end
    endgenerate

    logic [5:0]       seq_q,  seq_d;
    logic [63:0]      buf_q,  buf_d;
    logic [63:0]      data_q, data_d;
    logic [6:0]       w_cnt;
    logic [63:0]      w_mask;
    logic [BLK_W-1:0] w_blk;
    logic [127:0]     w_cat;
    logic             w_pause;

    always_comb begin
        w_pause = (seq_q == SEQ_LAST);
        w_cnt   = {seq_q, 1'b0};
        // Only the low cnt residue bits are meaningful; mask the rest off.
        w_mask  = ~(64'hFFFF_FFFF_FFFF_FFFF << w_cnt);
        w_blk   = {encoded_tx_data, encoded_tx_hdr};
        w_cat   = ({62'd0, w_blk} << w_cnt) | {64'd0, buf_q & w_mask};

        seq_d   = seq_q;
        buf_d   = buf_q;
        data_d  = data_q;
        if (w_pause) begin
            data_d = buf_q & w_mask;
            buf_d  = 64'd0;
            seq_d  = 6'd0;
        end else begin
            data_d = w_cat[63:0];
            buf_d  = w_cat[127:64];
            seq_d  = seq_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q  <= 6'd0;
            buf_q  <= 64'd0;
            data_q <= 64'd0;
        end else begin
            seq_q  <= seq_d;
            buf_q  <= buf_d;
            data_q <= data_d;
        end
    end

    // Pause is a pure decode of registered state: no input-to-output path.
    assign tx_pause       = w_pause;
    assign serdes_tx_data = data_q;
    assign tx_seq         = seq_q;

endmodule
`default_nettype wire

// File: tb/tb_baser_tx_gearbox_64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baser_tx_gearbox_64
//  Purpose  : Directed self-checking bench for baser_tx_gearbox_64.
//  Revision : 1.0  initial release
// ============================================================================
module tb_baser_tx_gearbox_64;

    logic        clk;
    logic        rst_n;
    logic [63:0] encoded_tx_data;
    logic [1:0]  encoded_tx_hdr;
    logic        tx_pause;
    logic [63:0] serdes_tx_data;
    logic [5:0]  tx_seq;

    int checks;
    int errors;

    localparam int NBLK   = 1000;
    localparam int NBITS  = NBLK * 66;
    localparam int MAXB   = 80000;

    logic exp_bits [MAXB];
    logic out_bits [MAXB];

    baser_tx_gearbox_64 #(.DATA_WIDTH(64), .HDR_WIDTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .encoded_tx_data (encoded_tx_data),
        .encoded_tx_hdr  (encoded_tx_hdr),
        .tx_pause        (tx_pause),
        .serdes_tx_data  (serdes_tx_data),
        .tx_seq          (tx_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset for two edges, release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [1:0] hdr, input logic [63:0] data);
        encoded_tx_hdr  = hdr;
        encoded_tx_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp_seq;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            encoded_tx_hdr  = 2'($urandom);
            encoded_tx_data = {$urandom, $urandom};
            @(posedge clk);
            #1;
            checks++;
            if (serdes_tx_data !== 64'd0 || tx_pause !== 1'b0 || tx_seq !== 6'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: data=%h pause=%b seq=%0d, required 0/0/0",
                         i, serdes_tx_data, tx_pause, tx_seq);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_seq = 6'(i);
            checks++;
            if (tx_seq !== exp_seq) begin
                errors++;
                $display("FAIL reset_seq edge%0d: tx_seq=%0d, required %0d", i + 1, tx_seq, exp_seq);
            end
            step(2'($urandom), {$urandom, $urandom});
        end
    endtask

    task automatic test_pattern();
        logic [63:0] exp_w;
        logic        exp_p;
        int          m;
        do_reset();
        for (int n = 0; n < 99; n++) begin
            step(2'b01, 64'd0);
            m     = n % 33;
            exp_w = (m < 32) ? (64'h1 << (2 * m)) : 64'h0;
            exp_p = (((n + 1) % 33) == 32);
            checks++;
            if (serdes_tx_data !== exp_w) begin
                errors++;
                $display("FAIL pattern word%0d: got %h, required %h", n, serdes_tx_data, exp_w);
            end
            checks++;
            if (tx_pause !== exp_p) begin
                errors++;
                $display("FAIL pattern pause cyc%0d: got %b, required %b", n + 1, tx_pause, exp_p);
            end
        end
    endtask

    task automatic test_pause_robust();
        logic [63:0] xd;
        logic [1:0]  xh;
        logic [63:0] exp_w;
        xd = {$urandom, $urandom};
        xh = 2'($urandom);
        do_reset();
        repeat (32) step(2'b01, 64'd0);
        checks++;
        if (tx_pause !== 1'b1) begin
            errors++;
            $display("FAIL pause_flag: got %b, required 1", tx_pause);
        end
        step(~xh, ~xd);
        checks++;
        if (serdes_tx_data !== 64'd0) begin
            errors++;
            $display("FAIL pause_drain: got %h, required 0", serdes_tx_data);
        end
        step(xh, xd);
        exp_w = {xd[61:0], xh};
        checks++;
        if (serdes_tx_data !== exp_w) begin
            errors++;
            $display("FAIL pause_intended: got %h, required %h", serdes_tx_data, exp_w);
        end
        step(2'b01, 64'd0);
        exp_w = 64'h4 | {62'd0, xd[63:62]};
        checks++;
        if (serdes_tx_data !== exp_w) begin
            errors++;
            $display("FAIL pause_tail: got %h, required %h", serdes_tx_data, exp_w);
        end
    endtask

    task automatic test_round_trip();
        logic [65:0] blk;
        int nexp;
        int nout;
        int nblk;
        int cyc;
        int bad;
        int first_bad;
        nexp = 0;
        nout = 0;
        nblk = 0;
        cyc  = 0;
        do_reset();
        while (nout < NBITS && cyc < 2000) begin
            blk = {$urandom, $urandom, 2'($urandom)};
            if (!tx_pause) begin
                for (int b = 0; b < 66; b++) exp_bits[nexp + b] = blk[b];
                nexp += 66;
                nblk++;
            end
            step(blk[1:0], blk[65:2]);
            for (int b = 0; b < 64; b++) out_bits[nout + b] = serdes_tx_data[b];
            nout += 64;
            cyc++;
        end
        checks++;
        if (nout < NBITS || nblk < NBLK) begin
            errors++;
            $display("FAIL rt_budget: out_bits=%0d blocks=%0d, required >=%0d / >=%0d",
                     nout, nblk, NBITS, NBLK);
        end
        bad       = 0;
        first_bad = -1;
        for (int b = 0; b < NBITS; b++) begin
            if (out_bits[b] !== exp_bits[b]) begin
                bad++;
                if (first_bad < 0) first_bad = b;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rt_stream: %0d bits differ, first at bit %0d, required 0 differing bits",
                     bad, first_bad);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (17) step(2'b01, 64'd0);
        checks++;
        if (tx_seq !== 6'd17) begin
            errors++;
            $display("FAIL mid_seq17: got %0d, required 17", tx_seq);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (serdes_tx_data !== 64'd0 || tx_pause !== 1'b0 || tx_seq !== 6'd0) begin
            errors++;
            $display("FAIL mid_async: data=%h pause=%b seq=%0d, required 0/0/0",
                     serdes_tx_data, tx_pause, tx_seq);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b01, 64'd0);
        checks++;
        if (serdes_tx_data !== 64'h1 || tx_seq !== 6'd1) begin
            errors++;
            $display("FAIL mid_restart0: data=%h seq=%0d, required 1/1", serdes_tx_data, tx_seq);
        end
        step(2'b01, 64'd0);
        checks++;
        if (serdes_tx_data !== 64'h4) begin
            errors++;
            $display("FAIL mid_restart1: data=%h, required 4", serdes_tx_data);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        encoded_tx_hdr  = 2'b00;
        encoded_tx_data = 64'd0;
        #3;
        test_reset();
        test_pattern();
        test_pause_robust();
        test_round_trip();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/baser_tx_gearbox_64.md
# baser_tx_gearbox_64

Transmit gearbox for the 10GBASE-R datapath, directly downstream of the 64-bit BASE-R frame transmitter/encoder. It packs 66-bit blocks (2-bit sync header plus 64-bit payload) into a continuous stream of 64-bit SerDes words, producing one output word every clock. Upstream is throttled with a pause strobe: 32 blocks are accepted in every 33 cycles, and the spare cycle drains the accumulated bits.

## Interface
- DATA_WIDTH, 64: block payload and SerDes word width; only 64 is supported (elaboration error otherwise).
- HDR_WIDTH, 2: sync header width; only 2 is supported.
- clk  input  1  single clock for all logic.
- rst_n  input  1  reset; asynchronous, active-low.
- encoded_tx_data  input  DATA_WIDTH  block payload from the encoder; bit 0 is transmitted first.
- encoded_tx_hdr  input  HDR_WIDTH  sync header; bit 0 is transmitted first, ahead of payload bit 0.
- tx_pause  output  1  high means the input is not consumed this cycle; upstream must hold its block.
- serdes_tx_data  output  DATA_WIDTH  gearboxed word to the SerDes; bit 0 is transmitted first.
- tx_seq  output  6  current sequence count, 0..32 (status/debug).

## Operation
- Block bit order: blk[65:0] = {encoded_tx_data, encoded_tx_hdr}, with blk[0] first on the wire.
- State: sequence counter seq (6 bits, 0..32), residue buffer buf (62 bits) and residue count cnt = 2*seq bits. Only buf[cnt-1:0] is meaningful.
- seq 0..31 (accept cycle):
  - tx_pause = 0.
  - Form cat = {blk, buf[cnt-1:0]} (128 bits max; residue is lower and goes first).
  - Register serdes_tx_data <= cat[63:0].
  - buf <= cat[cnt+65:64] (cnt+2 bits).
  - seq <= seq+1.
- seq 32 (pause cycle):
  - tx_pause = 1 and the input is ignored.
  - At this point cnt = 64, so register serdes_tx_data <= buf-equivalent 64 residue bits.
  - Residue becomes empty; seq <= 0.
  - The residue storage must therefore hold 64 bits at seq = 32. Implement buf as 64 bits.
- tx_pause is decoded from registered seq (tx_pause = (seq == 32)) and has no combinational path from the inputs.
- tx_seq = seq.
- Residue bits above cnt are don't-care but must not leak into the output. Mask or shift explicitly; a variable part-select on the 128-bit concatenation is acceptable.
- No input valid qualifier: the encoder produces a block (data or idle) every non-paused cycle.

## Timing
- Reset (rst_n low, asynchronous): seq = 0, buffer cleared, serdes_tx_data = 0, tx_pause = 0, tx_seq = 0.
- Reset release: the first block is sampled on the first rising edge with rst_n high.
- Latency: a block sampled at edge k appears, starting at bit offset 2*seq, in serdes_tx_data registered at edge k. It is visible in the following cycle, and its tail bits appear one edge later.
- Cadence: tx_pause is high exactly one cycle in every 33, first during the 33rd cycle after reset release (seq = 32). The pattern is periodic with no drift.
- Throughput: 32×66 = 33×64 = 2112 bits per period. The output never idles and never duplicates bits.
- Upstream changes encoded_tx_* while tx_pause = 1: the change is ignored, with no corruption; the held value is sampled next cycle.
- Reset mid-period: all residue is discarded and the sequence restarts at 0. Partial words are not flushed.

## Test plan
- Pattern check: hdr = 2'b01 and data = 0 every block.
  - serdes_tx_data for output words n = 0..31 must equal 64'h1 << (2n).
  - Word 32 must equal 64'h0, then the pattern repeats.
  - tx_pause must be high in cycles 32, 65 and 98 after release.
- Round trip: 1000 random 66-bit blocks, with the bench honouring tx_pause.
  - Concatenate the output words LSB-first.
  - The resulting bit stream must equal the concatenated input blocks exactly, with zero bit slip.
- Pause robustness: drive a random block while tx_pause = 1, then the intended block.
  - The output stream must contain only the intended block.
- Reset mid-period: assert rst_n low at seq = 17.
  - serdes_tx_data, tx_pause and tx_seq must be 0 immediately (asynchronous).
  - After release, the hdr = 01 pattern restarts at 64'h1.
- Reset values: hold rst_n low for 5 cycles with random inputs.
  - Outputs must stay 0 throughout.
  - tx_seq must be 0, 1, 2 on the first three edges after release.
